// File: rtl/regfile_wb_sink.sv
// regfile_wb_sink: 32 x XLEN integer register file at the writeback sink.
// Absorbs writeback results, serves two decode read ports with same-cycle
// write-to-read bypass, and tracks pending writes to stall RAW/WAW hazards.

// One decode read port: x0 / bypass / array select plus its source hazard.
module regfile_rd_port #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   addr,
  input  logic            used,
  input  logic            busy_bit,
  input  logic [XLEN-1:0] reg_val,
  input  logic            wb_regwrite,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data,
  output logic            hz
);
  logic hit;
  assign hit = wb_regwrite && (wb_rd == addr);

  // Priority: x0 reads zero, then in-flight writeback, then stored value.
  always_comb begin
    data = reg_val;
    if (addr == '0)  data = '0;
    else if (hit)    data = wb_data;
  end

  // A busy source that is being written this cycle is already satisfied.
  assign hz = used && (addr != '0) && busy_bit && !hit;
endmodule

module regfile_wb_sink #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_regwrite,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  input  logic             iss_valid,
  input  logic             iss_rs1_used,
  input  logic             iss_rs2_used,
  input  logic             iss_regwrite,
  input  logic [AW-1:0]    iss_rd,
  output logic             stall,
  output logic [CNT_W-1:0] wb_count
);
  localparam int NPORT = 2;

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy;

  logic [NPORT-1:0][AW-1:0]   rd_addr;
  logic [NPORT-1:0]           rd_used;
  logic [NPORT-1:0][XLEN-1:0] rd_data;
  logic [NPORT-1:0]           hz;

  logic wb_commit, waw, iss_fire;

  assign rd_addr = {rs2_addr, rs1_addr};
  assign rd_used = {iss_rs2_used, iss_rs1_used};

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    regfile_rd_port #(.XLEN(XLEN), .AW(AW)) u_port (
      .addr        (rd_addr[p]),
      .used        (rd_used[p]),
      .busy_bit    (busy[rd_addr[p]]),
      .reg_val     (regs[rd_addr[p]]),
      .wb_regwrite (wb_regwrite),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .data        (rd_data[p]),
      .hz          (hz[p])
    );
  end

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];

  assign wb_commit = wb_regwrite && (wb_rd != '0);
  assign waw       = iss_regwrite && (iss_rd != '0) && busy[iss_rd]
                     && !(wb_regwrite && (wb_rd == iss_rd));
  assign stall     = iss_valid && (|hz || waw);
  assign iss_fire  = iss_valid && !stall;

  // Register array, pending-write scoreboard and commit counter. The busy
  // set comes after the clear so a new producer wins over a retiring one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs     <= '0;
      busy     <= '0;
      wb_count <= '0;
    end else begin
      if (wb_commit) begin
        regs[wb_rd] <= wb_data;
        busy[wb_rd] <= 1'b0;
        wb_count    <= wb_count + CNT_W'(1);
      end
      if (iss_fire && iss_regwrite && (iss_rd != '0))
        busy[iss_rd] <= 1'b1;
    end
  end
endmodule
